// File: rtl/seq_signed_divider_if.sv
// Handshake and result bundle between the ALU sequencer and the signed divider.
interface seq_signed_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic               start;
    logic [WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]   divisor;
    logic               busy;
    logic               done;
    logic               div_by_zero;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic [2*WIDTH-1:0] result;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div_by_zero, quotient, remainder, result
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_by_zero, quotient, remainder, result
    );
endinterface

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: magnitude restoring shift-subtract, one quotient bit
// per clock, then sign fixup of quotient and remainder for the HI/LO result path.
module seq_signed_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_signed_divider_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP, DONE} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] dvd, dvd_d;     // dividend magnitude, shifted out as quotient shifts in
    logic [WIDTH-1:0] dsr, dsr_d;
    logic [WIDTH-1:0] rem, rem_d;
    logic [WIDTH-1:0] quo, quo_d;
    logic [WIDTH-1:0] rmo, rmo_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             sign_q, sign_q_d, sign_r, sign_r_d;
    logic             busy, busy_d, done, done_d, dbz, dbz_d;
    logic [WIDTH:0]   rem_sh, trial;

    // Next-state and datapath update
    always_comb begin
        state_d  = state;
        dvd_d    = dvd;
        dsr_d    = dsr;
        rem_d    = rem;
        quo_d    = quo;
        rmo_d    = rmo;
        cnt_d    = cnt;
        sign_q_d = sign_q;
        sign_r_d = sign_r;
        dbz_d    = dbz;
        rem_sh   = {rem, dvd[WIDTH-1]};
        trial    = rem_sh - {1'b0, dsr};

        case (state)
            IDLE, DONE: begin
                if (state == DONE) state_d = IDLE;
                if (bus.start) begin
                    // -(-2^(WIDTH-1)) wraps to itself, which is the correct unsigned magnitude
                    dvd_d    = bus.dividend[WIDTH-1] ? WIDTH'(-bus.dividend) : bus.dividend;
                    dsr_d    = bus.divisor[WIDTH-1]  ? WIDTH'(-bus.divisor)  : bus.divisor;
                    sign_q_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    sign_r_d = bus.dividend[WIDTH-1];
                    rem_d    = '0;
                    cnt_d    = '0;
                    if (bus.divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '0;
                        rmo_d   = bus.dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = DIVIDE;
                        dbz_d   = 1'b0;
                    end
                end
            end
            DIVIDE: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    dvd_d = {dvd[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    dvd_d = {dvd[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) state_d = FIXUP;
            end
            FIXUP: begin
                quo_d   = sign_q ? WIDTH'(-dvd) : dvd;
                rmo_d   = sign_r ? WIDTH'(-rem) : rem;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == DIVIDE) || (state_d == FIXUP);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            dvd    <= '0;
            dsr    <= '0;
            rem    <= '0;
            quo    <= '0;
            rmo    <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dbz    <= 1'b0;
        end else begin
            state  <= state_d;
            dvd    <= dvd_d;
            dsr    <= dsr_d;
            rem    <= rem_d;
            quo    <= quo_d;
            rmo    <= rmo_d;
            cnt    <= cnt_d;
            sign_q <= sign_q_d;
            sign_r <= sign_r_d;
            busy   <= busy_d;
            done   <= done_d;
            dbz    <= dbz_d;
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.div_by_zero = dbz;
    assign bus.quotient    = quo;
    assign bus.remainder   = rmo;
    assign bus.result      = {rmo, quo};
endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider: expected results are queued at start and
// checked against the done pulse, including latency, sign cases and reset abort.
module tb_seq_signed_divider;
    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    seq_signed_divider_if #(.WIDTH(W)) bus ();
    seq_signed_divider #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Reference: 64-bit signed arithmetic truncates toward zero and wraps the overflow case
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sb_;
        longint q64, r64;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        if (b == '0) begin
            e.q = '0; e.r = a; e.dbz = 1'b1; e.lat = 1;
        end else begin
            q64 = sa / sb_;
            r64 = sa % sb_;
            e.q = q64[W-1:0]; e.r = r64[W-1:0]; e.dbz = 1'b0; e.lat = W + 2;
        end
        return e;
    endfunction

    // Called at a negedge; start is sampled by the next rising edge (E0)
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.dividend = $urandom; bus.divisor = $urandom;
    endtask

    // Sample k = value seen just before edge Ek; returns at the negedge where done is high
    task automatic wait_done(input int restart_at);
        exp_t e;
        bit   seen = 1'b0;
        int   lat = 0;
        int   busy_bad = 0;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty: no expected entry queued");
            miscompares++; vectors++;
            return;
        end
        e = sb.pop_front();
        for (int k = 1; k <= 100 && !seen; k++) begin
            @(negedge clk);
            bus.start = (k == restart_at);
            if (k == restart_at) begin bus.dividend = 32'd1; bus.divisor = 32'd1; end
            if (bus.done === 1'b1) begin seen = 1'b1; lat = k; end
            else if (bus.busy !== 1'b1) busy_bad++;
        end
        bus.start = 1'b0;
        vectors++;
        if (!seen) begin
            $display("FAIL done_timeout: done not seen within 100 edges, required edge %0d", e.lat);
            miscompares++;
            return;
        end
        vectors++;
        if (lat !== e.lat) begin $display("FAIL latency: got E%0d required E%0d", lat, e.lat); miscompares++; end
        vectors++;
        if (bus.quotient !== e.q) begin $display("FAIL quotient: got %h required %h", bus.quotient, e.q); miscompares++; end
        vectors++;
        if (bus.remainder !== e.r) begin $display("FAIL remainder: got %h required %h", bus.remainder, e.r); miscompares++; end
        vectors++;
        if (bus.result !== {e.r, e.q}) begin $display("FAIL result: got %h required %h", bus.result, {e.r, e.q}); miscompares++; end
        vectors++;
        if (bus.div_by_zero !== e.dbz) begin $display("FAIL div_by_zero: got %b required %b", bus.div_by_zero, e.dbz); miscompares++; end
        vectors++;
        if (busy_bad !== 0) begin $display("FAIL busy_during: busy low on %0d edges required 0", busy_bad); miscompares++; end
        vectors++;
        if (bus.busy !== 1'b0) begin $display("FAIL busy_at_done: got %b required 0", bus.busy); miscompares++; end
    endtask

    task automatic check_pulse();
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0) begin $display("FAIL done_pulse: done still %b one cycle later, required 0", bus.done); miscompares++; end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        issue(a, b);
        wait_done(0);
        check_pulse();
    endtask

    task automatic check_zero(input string tag);
        vectors++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder, bus.result} !== '0) begin
            $display("FAIL %s: busy=%b done=%b dbz=%b q=%h r=%h result=%h required all 0",
                     tag, bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder, bus.result);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_op(32'd100, 32'd7);
        vectors++;
        if (bus.result !== 64'h00000002_0000000E) begin
            $display("FAIL result_100_7: got %h required 000000020000000e", bus.result); miscompares++;
        end
    endtask

    task automatic test_signs();
        run_op(-32'sd100, 32'd7);
        vectors++;
        if (bus.quotient !== 32'hFFFFFFF2 || bus.remainder !== 32'hFFFFFFFE) begin
            $display("FAIL neg_dividend: q=%h r=%h required fffffff2 fffffffe", bus.quotient, bus.remainder); miscompares++;
        end
        run_op(32'd100, -32'sd7);
        run_op(-32'sd100, -32'sd7);
    endtask

    task automatic test_div_by_zero();
        run_op(32'd7, 32'd0);
        run_op(32'd9, 32'd3);
        run_op(32'h80000000, 32'd0);
    endtask

    task automatic test_overflow();
        run_op(32'h80000000, 32'hFFFFFFFF);
        run_op(32'h80000000, 32'd1);
        run_op(32'h7FFFFFFF, 32'h80000000);
        run_op(32'h80000000, 32'h80000000);
    endtask

    task automatic test_start_while_busy();
        @(negedge clk);
        issue(32'd50, 32'd5);
        wait_done(10);
        check_pulse();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        issue(32'd1000, 32'd33);
        wait_done(0);
        issue(-32'sd1000, 32'd0);
        wait_done(0);
        issue(32'd12, -32'sd5);
        wait_done(0);
        check_pulse();
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = (i % 2 == 0) ? W'($urandom_range(1, 1000)) : W'($urandom);
            if (i == 3) b = -b;
            run_op(a, b);
        end
    endtask

    task automatic test_reset_mid_divide();
        int late_done = 0;
        @(negedge clk);
        issue(32'd12345678, 32'd3);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        void'(sb.pop_front());
        #1;
        check_zero("reset_mid_divide");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) late_done++;
        end
        vectors++;
        if (late_done !== 0) begin $display("FAIL aborted_done: done seen %0d times required 0", late_done); miscompares++; end
        run_op(32'd8, 32'd3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_div_by_zero();
        test_overflow();
        test_start_while_busy();
        test_back_to_back();
        test_random();
        test_reset_mid_divide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
